// File: rtl/apu_frame_sequencer.sv
// apu_frame_sequencer: 512 Hz DIV tap -> 8-step frame sequence, channel-1 low-rate clocks and trigger pulse
//   ajer_2mhz / apu_reset : clock, async active-high reset
//   apu_en, div_bit       : master enable, 512 Hz DIV tap (falling edge advances)
//   apu_wr, ff14, d7      : NR14 write with trigger bit
//   step, *_tick          : frame step and one-cycle length/sweep/envelope clocks
//   horu/bufy/byfe/len_skip, ch1_restart : derived rates and channel-1 trigger pulse
module apu_frame_sequencer #(
    parameter int         RESTART_W  = 2,
    parameter logic [2:0] RESET_STEP = 3'd7
) (
    input  logic       ajer_2mhz,
    input  logic       apu_reset,
    input  logic       apu_en,
    input  logic       div_bit,
    input  logic       apu_wr,
    input  logic       ff14,
    input  logic       d7,
    output logic [2:0] step,
    output logic       len_tick,
    output logic       sweep_tick,
    output logic       env_tick,
    output logic       horu_512hz,
    output logic       bufy_256hz,
    output logic       byfe_128hz,
    output logic       len_skip,
    output logic       ch1_restart
);
    localparam logic [1:0] IDLE = 2'd0, ARM = 2'd1, FIRE = 2'd2;
    logic [1:0] state;
    logic [2:0] cnt;
    logic       pend;
    logic       adv, trig;
    logic [2:0] nxt;
    assign adv         = horu_512hz & ~div_bit & apu_en;
    assign trig        = apu_wr & ff14 & d7 & apu_en;
    assign nxt         = step + 3'd1;
    assign bufy_256hz  = step[0];
    assign byfe_128hz  = step[1];
    assign len_skip    = ~step[0];
    assign ch1_restart = state == FIRE;
    // ticks are decoded from the step being entered so they coincide with it
    always_ff @(posedge ajer_2mhz or posedge apu_reset) begin
        if (apu_reset) begin
            step       <= RESET_STEP;
            len_tick   <= 1'b0;
            sweep_tick <= 1'b0;
            env_tick   <= 1'b0;
            horu_512hz <= 1'b0;
        end else begin
            horu_512hz <= div_bit;
            step       <= !apu_en ? RESET_STEP : adv ? nxt : step;
            len_tick   <= adv & ~nxt[0];
            sweep_tick <= adv & (nxt[1:0] == 2'b10);
            env_tick   <= adv & (nxt == 3'd7);
        end
    end
    // a trigger on the last FIRE cycle counts as queued, so it re-arms directly
    always_ff @(posedge ajer_2mhz or posedge apu_reset) begin
        if (apu_reset || !apu_en) begin
            state <= IDLE;
            cnt   <= 3'd0;
            pend  <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= trig ? ARM : IDLE;
                ARM: begin
                    state <= FIRE;
                    cnt   <= 3'(RESTART_W);
                end
                FIRE: begin
                    if (cnt == 3'd1) begin
                        state <= (pend | trig) ? ARM : IDLE;
                        pend  <= 1'b0;
                    end else begin
                        cnt  <= cnt - 3'd1;
                        pend <= pend | trig;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
